code_entry: RTL and testbench

CODE_ENTRY -- requirements
Module: code_entry

---
 rtl/codebreak_pkg.sv | 49 ++++
 rtl/key_press_edge.sv | 55 +++++
 rtl/code_entry.sv | 211 +++++++++++++++++++++
 tb/tb_code_entry.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codebreak_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codebreak_pkg
// Description : Shared definitions for the code-entry block: keypad codes,
//               FSM state encoding, BCD digit width and a helper that counts
//               digit values two codes have in common (duplicates honoured).
// Revision    : 1.0 - initial release
// ============================================================================
package codebreak_pkg;

    localparam int BCD_W     = 4;
    localparam int CODE_DIGS = 4;
    localparam int CODE_W    = BCD_W * CODE_DIGS;

    localparam logic [BCD_W-1:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [BCD_W-1:0] KEY_BKSP      = 4'hA;
    localparam logic [BCD_W-1:0] KEY_ENTER     = 4'hF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY  = 3'd1,
        CHECK  = 3'd2,
        RESULT = 3'd3,
        WIN    = 3'd4,
        LOSE   = 3'd5
    } state_e;

    // Sum over every BCD value of min(occurrences in a, occurrences in b).
    // This is the number of digits the two codes share regardless of position.
    function automatic logic [2:0] common_digits(input logic [CODE_W-1:0] a,
                                                 input logic [CODE_W-1:0] b);
        logic [2:0] total;
        logic [2:0] cnt_a;
        logic [2:0] cnt_b;
        total = '0;
        for (int v = 0; v < 10; v++) begin
            cnt_a = '0;
            cnt_b = '0;
            for (int p = 0; p < CODE_DIGS; p++) begin
                if (a[p*BCD_W +: BCD_W] == 4'(v)) cnt_a = cnt_a + 3'd1;
                if (b[p*BCD_W +: BCD_W] == 4'(v)) cnt_b = cnt_b + 3'd1;
            end
            total = total + ((cnt_a < cnt_b) ? cnt_a : cnt_b);
        end
        return total;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_press_edge.sv
`default_nettype none
// ============================================================================
// Module      : key_press_edge
// Description : Turns the level key_valid into a single-cycle press pulse on
//               its rising edge and registers the key code alongside it.
//               The history flop resets to 1 (and is forced to 1 by clear) so
//               a key already held is not taken until released and pressed.
// Ports       : clk       - clock, rising edge
//               rst_n     - synchronous active-low reset
//               clear     - forget any press in progress (new game)
//               key_valid - level, high while a key is held
//               key_code  - raw key value
//               press     - one-cycle pulse, one cycle after the rising edge
//               key       - key code captured with the press
// Revision    : 1.0 - initial release
// ============================================================================
module key_press_edge
    import codebreak_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             key_valid,
    input  logic [BCD_W-1:0] key_code,
    output logic             press,
    output logic [BCD_W-1:0] key
);

    logic             valid_hist_q, valid_hist_d;
    logic             press_q, press_d;
    logic [BCD_W-1:0] key_q, key_d;

    always_comb begin
        valid_hist_d = clear ? 1'b1 : key_valid;
        press_d      = ~clear & key_valid & ~valid_hist_q;
        key_d        = key_code;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_hist_q <= 1'b1;
            press_q      <= 1'b0;
            key_q        <= '0;
        end else begin
            valid_hist_q <= valid_hist_d;
            press_q      <= press_d;
            key_q        <= key_d;
        end
    end

    assign press = press_q;
    assign key   = key_q;

endmodule
`default_nettype wire

// File: rtl/code_entry.sv
`default_nettype none
// ============================================================================
// Module      : code_entry
// Description : Keypad code-breaking game. A 4-digit BCD secret is latched by
//               secret_load; the player enters digits (with backspace) and
//               submits with enter. Each guess is scored as exact matches and,
//               optionally, right-digit/wrong-place matches. The game ends in
//               WIN on a full match or LOSE after MAX_TRIES guesses.
// Options     : CODE_ENTRY_PARTIAL_EN - when defined, build the partial-match
//               counter; otherwise partial is tied to 0.
// Ports       : clk, rst_n       - clock, synchronous active-low reset
//               key_code         - keypad value (0-9 digit, A bksp, F enter)
//               key_valid        - level, high while a key is held
//               secret           - 4 BCD digits, first digit in [15:12]
//               secret_load      - pulse: latch secret, start a new game
//               guess            - digits entered, newest in [3:0]
//               digit_cnt        - digits entered, 0..4
//               exact, partial   - score of the last submitted guess
//               result_valid     - one-cycle pulse when the score updates
//               attempts         - guesses submitted this game
//               win, lose        - sticky end-of-game flags
// Revision    : 1.0 - initial release
// ============================================================================
module code_entry
    import codebreak_pkg::*;
#(
    parameter int MAX_TRIES = 8,
    parameter int DIGITS    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        key_code,
    input  logic              key_valid,
    input  logic [15:0]       secret,
    input  logic              secret_load,
    output logic [15:0]       guess,
    output logic [2:0]        digit_cnt,
    output logic [2:0]        exact,
    output logic [2:0]        partial,
    output logic              result_valid,
    output logic [3:0]        attempts,
    output logic              win,
    output logic              lose
);

    localparam logic [2:0] FULL_CNT  = 3'(DIGITS);
    localparam logic [3:0] TRY_LIMIT = 4'(MAX_TRIES);

    logic             key_press;
    logic [BCD_W-1:0] key_val;
    logic             key_is_digit;
    logic [2:0]       exact_now;

    state_e           state_q, state_d;
    logic [15:0]      secret_q, secret_d;
    logic [15:0]      guess_q, guess_d;
    logic [2:0]       digit_cnt_q, digit_cnt_d;
    logic [2:0]       exact_q, exact_d;
    logic             result_valid_q, result_valid_d;
    logic [3:0]       attempts_q, attempts_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;

    key_press_edge u_key_press_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (secret_load),
        .key_valid (key_valid),
        .key_code  (key_code),
        .press     (key_press),
        .key       (key_val)
    );

    assign key_is_digit = (key_val <= KEY_DIGIT_MAX);

    // Positional matches between the latched secret and the current guess.
    always_comb begin
        exact_now = '0;
        for (int p = 0; p < DIGITS; p++) begin
            if (secret_q[p*BCD_W +: BCD_W] == guess_q[p*BCD_W +: BCD_W])
                exact_now = exact_now + 3'd1;
        end
    end

    always_comb begin
        state_d        = state_q;
        secret_d       = secret_q;
        guess_d        = guess_q;
        digit_cnt_d    = digit_cnt_q;
        exact_d        = exact_q;
        result_valid_d = 1'b0;
        attempts_d     = attempts_q;
        win_d          = win_q;
        lose_d         = lose_q;

        // A new game takes priority over anything else, including a key
        // press accepted in the same cycle.
        if (secret_load) begin
            secret_d    = secret;
            guess_d     = '0;
            digit_cnt_d = '0;
            attempts_d  = '0;
            win_d       = 1'b0;
            lose_d      = 1'b0;
            state_d     = ENTRY;
        end else begin
            case (state_q)
                IDLE: begin
                end
                ENTRY: begin
                    if (key_press) begin
                        if (key_is_digit) begin
                            if (digit_cnt_q < FULL_CNT) begin
                                guess_d     = {guess_q[15-BCD_W:0], key_val};
                                digit_cnt_d = digit_cnt_q + 3'd1;
                            end
                        end else if (key_val == KEY_BKSP) begin
                            if (digit_cnt_q != 3'd0) begin
                                guess_d     = {{BCD_W{1'b0}}, guess_q[15:BCD_W]};
                                digit_cnt_d = digit_cnt_q - 3'd1;
                            end
                        end else if (key_val == KEY_ENTER) begin
                            if (digit_cnt_q == FULL_CNT) begin
                                attempts_d = attempts_q + 4'd1;
                                state_d    = CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    exact_d        = exact_now;
                    result_valid_d = 1'b1;
                    state_d        = RESULT;
                end
                RESULT: begin
                    if (exact_q == FULL_CNT) begin
                        win_d   = 1'b1;
                        state_d = WIN;
                    end else if (attempts_q == TRY_LIMIT) begin
                        lose_d  = 1'b1;
                        state_d = LOSE;
                    end else begin
                        guess_d     = '0;
                        digit_cnt_d = '0;
                        state_d     = ENTRY;
                    end
                end
                WIN, LOSE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            secret_q       <= '0;
            guess_q        <= '0;
            digit_cnt_q    <= '0;
            exact_q        <= '0;
            result_valid_q <= 1'b0;
            attempts_q     <= '0;
            win_q          <= 1'b0;
            lose_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            secret_q       <= secret_d;
            guess_q        <= guess_d;
            digit_cnt_q    <= digit_cnt_d;
            exact_q        <= exact_d;
            result_valid_q <= result_valid_d;
            attempts_q     <= attempts_d;
            win_q          <= win_d;
            lose_q         <= lose_d;
        end
    end

`ifdef CODE_ENTRY_PARTIAL_EN
    logic [2:0] partial_q, partial_d;

    // Shared digits minus those already counted as exact; scored in CHECK
    // together with exact so both update on the same result_valid.
    always_comb begin
        partial_d = partial_q;
        if (!secret_load && state_q == CHECK)
            partial_d = common_digits(secret_q, guess_q) - exact_now;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) partial_q <= '0;
        else        partial_q <= partial_d;
    end

    assign partial = partial_q;
`else
    assign partial = 3'd0;
`endif

    assign guess        = guess_q;
    assign digit_cnt    = digit_cnt_q;
    assign exact        = exact_q;
    assign result_valid = result_valid_q;
    assign attempts     = attempts_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule
`default_nettype wire

// File: tb/tb_code_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_entry
// Description : Self-checking bench for code_entry (MAX_TRIES = 2). A game
//               model tracks the digits typed, attempts and game outcome;
//               each scored guess is pushed to a scoreboard that a monitor
//               pops on every result_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_entry;

    localparam int MAX_TRIES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] secret;
    logic        secret_load;
    logic [15:0] guess;
    logic [2:0]  digit_cnt;
    logic [2:0]  exact;
    logic [2:0]  partial;
    logic        result_valid;
    logic [3:0]  attempts;
    logic        win;
    logic        lose;

    code_entry #(.MAX_TRIES(MAX_TRIES), .DIGITS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .secret       (secret),
        .secret_load  (secret_load),
        .guess        (guess),
        .digit_cnt    (digit_cnt),
        .exact        (exact),
        .partial      (partial),
        .result_valid (result_valid),
        .attempts     (attempts),
        .win          (win),
        .lose         (lose)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ex;
        int pa;
        int att;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Game model: phase 0 idle, 1 playing, 2 won, 3 lost.
    int m_secret[4];
    int m_dig[$];
    int m_att   = 0;
    int m_phase = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int model_guess();
        int g = 0;
        foreach (m_dig[i]) g = (g << 4) | m_dig[i];
        return g;
    endfunction

    task automatic apply_key(input int k);
        int   ex, tot, pa;
        int   cs[10];
        int   cg[10];
        exp_t e;
        if (m_phase != 1) return;
        if (k <= 9) begin
            if (m_dig.size() < 4) m_dig.push_back(k);
        end else if (k == 10) begin
            if (m_dig.size() > 0) void'(m_dig.pop_back());
        end else if (k == 15 && m_dig.size() == 4) begin
            ex  = 0;
            tot = 0;
            for (int v = 0; v < 10; v++) begin cs[v] = 0; cg[v] = 0; end
            for (int i = 0; i < 4; i++) begin
                if (m_dig[i] == m_secret[i]) ex++;
                cs[m_secret[i]]++;
                cg[m_dig[i]]++;
            end
            for (int v = 0; v < 10; v++) tot += (cs[v] < cg[v]) ? cs[v] : cg[v];
`ifdef CODE_ENTRY_PARTIAL_EN
            pa = tot - ex;
`else
            pa = 0;
`endif
            m_att++;
            e.ex  = ex;
            e.pa  = pa;
            e.att = m_att;
            sb.push_back(e);
            if (ex == 4)                 m_phase = 2;
            else if (m_att == MAX_TRIES) m_phase = 3;
            else                         m_dig.delete();
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".guess"},     int'(guess),     model_guess());
        check({tag, ".digit_cnt"}, int'(digit_cnt), m_dig.size());
        check({tag, ".attempts"},  int'(attempts),  m_att);
        check({tag, ".win"},       int'(win),       (m_phase == 2) ? 1 : 0);
        check({tag, ".lose"},      int'(lose),      (m_phase == 3) ? 1 : 0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=1 expected=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb.exact",    int'(exact),    e.ex);
                check("sb.partial",  int'(partial),  e.pa);
                check("sb.attempts", int'(attempts), e.att);
            end
        end
    end

    task automatic press(input int k, input int hold);
        apply_key(k);
        @(posedge clk); #1;
        key_code  = 4'(k);
        key_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1 key_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] s);
        @(posedge clk); #1;
        secret      = s;
        secret_load = 1'b1;
        @(posedge clk); #1;
        secret_load = 1'b0;
        for (int i = 0; i < 4; i++) m_secret[i] = int'(s[15-4*i -: 4]);
        m_dig.delete();
        m_att   = 0;
        m_phase = 1;
    endtask

    // Enter with explicit latency checks on result_valid.
    task automatic enter_timed();
        apply_key(15);
        @(posedge clk); #1;
        key_code  = 4'hF;
        key_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); check("rv_accept_cycle", int'(result_valid), 0);
        @(posedge clk); #1 key_valid = 1'b0;
        @(negedge clk); check("rv_check_cycle", int'(result_valid), 0);
        @(posedge clk);
        @(negedge clk); check("rv_two_after_enter", int'(result_valid), 1);
        @(posedge clk);
        @(negedge clk); check("rv_single_pulse", int'(result_valid), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] s;
        for (int i = 0; i < 4; i++) s[4*i +: 4] = 4'($urandom_range(0, 9));
        return s;
    endfunction

    initial begin
        int k;
        int cheat;
        int n;
        rst_n       = 1'b0;
        key_code    = 4'h3;
        key_valid   = 1'b1;   // key held across reset
        secret      = 16'h0;
        secret_load = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.guess",        int'(guess),        0);
        check("rst.digit_cnt",    int'(digit_cnt),    0);
        check("rst.exact",        int'(exact),        0);
        check("rst.partial",      int'(partial),      0);
        check("rst.result_valid", int'(result_valid), 0);
        check("rst.attempts",     int'(attempts),     0);
        check("rst.win",          int'(win),          0);
        check("rst.lose",         int'(lose),         0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Held key leaves reset, then a new game starts before release.
        repeat (3) @(posedge clk);
        load(16'h1234);
        repeat (3) @(posedge clk);
        #1 key_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_outputs("held_over_reset");

        // Full match wins on the first attempt.
        press(1, 2); press(2, 2); press(3, 2); press(4, 2);
        check_outputs("win_entry");
        enter_timed();
        check_outputs("win");
        press(5, 2);
        check_outputs("win_keys_ignored");

        // Duplicate digits: secret 1123, guess 3119.
        load(16'h1123);
        press(3, 2); press(1, 2); press(1, 2); press(9, 2); press(15, 2);
        check_outputs("dup_score");

        // Backspace, entry editing, then lockout after two wrong guesses.
        load(16'h1234);
        press(10, 2);
        check_outputs("bksp_at_zero");
        press(5, 2); press(6, 2); press(10, 2); press(7, 2); press(7, 2); press(8, 2);
        check("edit.guess", int'(guess), 16'h5778);
        press(9, 2);
        check_outputs("digit_when_full");
        press(15, 2);
        check_outputs("first_wrong");
        press(1, 2); press(1, 2); press(1, 2); press(1, 2); press(15, 2);
        check_outputs("lose");
        press(9, 2); press(10, 2);
        check_outputs("lose_keys_ignored");

        // Long hold gives one digit; enter short of four digits is ignored.
        load(16'h4321);
        press(5, 50);
        check_outputs("long_hold");
        press(6, 2); press(7, 2); press(15, 2);
        check_outputs("enter_short");

        // Key held across secret_load is not taken.
        @(posedge clk); #1 key_code = 4'h2; key_valid = 1'b1;
        repeat (2) @(posedge clk);
        load(16'h9876);
        repeat (3) @(posedge clk);
        #1 key_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_outputs("held_over_load");

        // Randomised games.
        for (int g = 0; g < 30; g++) begin
            load(rand_bcd());
            cheat = $urandom_range(0, 2);
            n = 0;
            while (m_phase == 1 && n < 30) begin
                if (m_dig.size() == 4 && $urandom_range(0, 3) == 0) begin
                    k = 15;
                end else if (cheat == 0 && m_dig.size() < 4) begin
                    k = m_secret[m_dig.size()];
                end else begin
                    k = $urandom_range(0, 15);
                end
                press(k, $urandom_range(1, 3));
                n++;
            end
            check_outputs("rand_game");
        end

        repeat (5) @(posedge clk);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
